iommu_pdt_walker: RTL

//  Process Directory Table walker: fills the PDTC on a lookup miss. Accepts a (device_id, process_id, pdtp) walk

---
 rtl/iommu_pkg.sv | 10 +
 rtl/iommu_pdt_walker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_pkg.sv
// Shared types for the IOMMU front end.
//   pc_t : 16-byte process context as stored in the PDTC (ta = dword0, fsc = dword1).
package iommu_pkg;

  typedef struct packed {
    logic [63:0] ta;
    logic [63:0] fsc;
  } pc_t;

endpackage

// File: rtl/iommu_pdt_walker.sv
// Process Directory Table walker. On a PDTC miss it walks 1-3 PDT levels over a
// single-outstanding 64-bit read port and returns the 16-byte process context.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   walk_valid_i/walk_ready_o          walk request handshake (ready only in IDLE)
//   walk_did_i, walk_pid_i             device_id / process_id of the walk
//   pdtp_mode_i, pdtp_ppn_i            PDT mode (Bare/PD8/PD17/PD20) and root page
//   mem_req_o/mem_addr_o/mem_gnt_i     read request, held with address until grant
//   mem_rvalid_i/mem_rdata_i/mem_err_i read response
//   flush_i/flush_dv_i/flush_did_i     PDTC invalidation snoop (marks walk stale)
//   update_o/up_did_o/up_pid_o/up_content_o  PDTC fill port
//   done_o/error_o/cause_o             walk completion and fault cause
module iommu_pdt_walker
  import iommu_pkg::*;
#(
  parameter int unsigned DEVICE_ID_WIDTH  = 24,
  parameter int unsigned PROCESS_ID_WIDTH = 20,
  parameter int unsigned PADDR_WIDTH      = 56
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        walk_valid_i,
  output logic                        walk_ready_o,
  input  logic [DEVICE_ID_WIDTH-1:0]  walk_did_i,
  input  logic [PROCESS_ID_WIDTH-1:0] walk_pid_i,
  input  logic [1:0]                  pdtp_mode_i,
  input  logic [43:0]                 pdtp_ppn_i,
  output logic                        mem_req_o,
  output logic [PADDR_WIDTH-1:0]      mem_addr_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [63:0]                 mem_rdata_i,
  input  logic                        mem_err_i,
  input  logic                        flush_i,
  input  logic                        flush_dv_i,
  input  logic [DEVICE_ID_WIDTH-1:0]  flush_did_i,
  output logic                        update_o,
  output logic [DEVICE_ID_WIDTH-1:0]  up_did_o,
  output logic [PROCESS_ID_WIDTH-1:0] up_pid_o,
  output pc_t                         up_content_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [11:0]                 cause_o
);

  localparam int unsigned CAUSE_W = 12;
  localparam logic [CAUSE_W-1:0] CAUSE_LOAD_FAULT = CAUSE_W'(265);
  localparam logic [CAUSE_W-1:0] CAUSE_NOT_VALID  = CAUSE_W'(266);
  localparam logic [CAUSE_W-1:0] CAUSE_MISCONF    = CAUSE_W'(267);

  typedef enum logic [3:0] {
    IDLE, NL_REQ, NL_WAIT, LF0_REQ, LF0_WAIT, LF1_REQ, LF1_WAIT, DONE, ERR
  } state_e;

  state_e                        state_q;
  logic [DEVICE_ID_WIDTH-1:0]    did_q;
  logic [PROCESS_ID_WIDTH-1:0]   pid_q;
  logic [43:0]                   ppn_q;
  logic                          lvl2_q;
  logic                          stale_q;
  logic [63:0]                   ta_q;
  logic [63:0]                   fsc_q;
  logic                          mem_req_q;
  logic [PADDR_WIDTH-1:0]        mem_addr_q;
  logic                          done_q;
  logic                          error_q;
  logic [CAUSE_W-1:0]            cause_q;

  logic flush_hit;
  logic cfg_bad;
  logic nl_rsvd;

  // Non-leaf entry address: root page + idx * 8.
  function automatic logic [PADDR_WIDTH-1:0] nl_addr(input logic [43:0] ppn, input logic [8:0] idx);
    return PADDR_WIDTH'({ppn, 12'h000}) + PADDR_WIDTH'({idx, 3'b000});
  endfunction

  // Leaf context address: page + idx * 16, dword1 at +8.
  function automatic logic [PADDR_WIDTH-1:0] lf_addr(input logic [43:0] ppn, input logic [7:0] idx,
                                                     input logic dw1);
    return PADDR_WIDTH'({ppn, 12'h000}) + PADDR_WIDTH'({idx, dw1, 3'b000});
  endfunction

  // Invalidation aimed at the walk in flight (global or same device).
  assign flush_hit = flush_i & (~flush_dv_i | (flush_did_i == did_q));

  // Mode Bare, or pid bits beyond what the PDT depth can index.
  always_comb begin
    cfg_bad = 1'b0;
    unique case (pdtp_mode_i)
      2'd0:    cfg_bad = 1'b1;
      2'd1:    cfg_bad = (walk_pid_i[19:8] != '0);
      2'd2:    cfg_bad = (walk_pid_i[19:17] != '0);
      default: cfg_bad = 1'b0;
    endcase
  end

  // Reserved bits in a non-leaf PDT entry.
  assign nl_rsvd = (mem_rdata_i[63:54] != '0) | (mem_rdata_i[9:1] != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      did_q      <= '0;
      pid_q      <= '0;
      ppn_q      <= '0;
      lvl2_q     <= 1'b0;
      stale_q    <= 1'b0;
      ta_q       <= '0;
      fsc_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cause_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cause_q <= '0;
      if (state_q != IDLE && flush_hit) stale_q <= 1'b1;

      case (state_q)
        IDLE: begin
          stale_q <= 1'b0;
          if (walk_valid_i) begin
            did_q <= walk_did_i;
            pid_q <= walk_pid_i;
            ppn_q <= pdtp_ppn_i;
            if (cfg_bad) begin
              state_q <= ERR;
              done_q  <= 1'b1;
              error_q <= 1'b1;
              cause_q <= CAUSE_MISCONF;
            end else if (pdtp_mode_i == 2'd3) begin
              lvl2_q     <= 1'b1;
              mem_req_q  <= 1'b1;
              mem_addr_q <= nl_addr(pdtp_ppn_i, 9'(walk_pid_i[19:17]));
              state_q    <= NL_REQ;
            end else if (pdtp_mode_i == 2'd2) begin
              lvl2_q     <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= nl_addr(pdtp_ppn_i, walk_pid_i[16:8]);
              state_q    <= NL_REQ;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= lf_addr(pdtp_ppn_i, walk_pid_i[7:0], 1'b0);
              state_q    <= LF0_REQ;
            end
          end
        end

        NL_REQ, LF0_REQ, LF1_REQ: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= (state_q == NL_REQ)  ? NL_WAIT :
                         (state_q == LF0_REQ) ? LF0_WAIT : LF1_WAIT;
          end
        end

        NL_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i || !mem_rdata_i[0] || nl_rsvd) begin
              state_q <= ERR;
              done_q  <= 1'b1;
              error_q <= 1'b1;
              cause_q <= mem_err_i ? CAUSE_LOAD_FAULT :
                         !mem_rdata_i[0] ? CAUSE_NOT_VALID : CAUSE_MISCONF;
            end else begin
              ppn_q     <= mem_rdata_i[53:10];
              mem_req_q <= 1'b1;
              if (lvl2_q) begin
                lvl2_q     <= 1'b0;
                mem_addr_q <= nl_addr(mem_rdata_i[53:10], pid_q[16:8]);
                state_q    <= NL_REQ;
              end else begin
                mem_addr_q <= lf_addr(mem_rdata_i[53:10], pid_q[7:0], 1'b0);
                state_q    <= LF0_REQ;
              end
            end
          end
        end

        LF0_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i || !mem_rdata_i[0]) begin
              state_q <= ERR;
              done_q  <= 1'b1;
              error_q <= 1'b1;
              cause_q <= mem_err_i ? CAUSE_LOAD_FAULT : CAUSE_NOT_VALID;
            end else begin
              ta_q       <= mem_rdata_i;
              mem_req_q  <= 1'b1;
              mem_addr_q <= lf_addr(ppn_q, pid_q[7:0], 1'b1);
              state_q    <= LF1_REQ;
            end
          end
        end

        LF1_WAIT: begin
          if (mem_rvalid_i) begin
            done_q <= 1'b1;
            if (mem_err_i) begin
              state_q <= ERR;
              error_q <= 1'b1;
              cause_q <= CAUSE_LOAD_FAULT;
            end else begin
              fsc_q   <= mem_rdata_i;
              state_q <= DONE;
            end
          end
        end

        DONE, ERR: state_q <= IDLE;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign walk_ready_o      = (state_q == IDLE);
  assign mem_req_o         = mem_req_q;
  assign mem_addr_o        = mem_addr_q;
  // A flush landing in the DONE cycle itself must still suppress the fill.
  assign update_o          = (state_q == DONE) & ~stale_q & ~flush_hit;
  assign up_did_o          = did_q;
  assign up_pid_o          = pid_q;
  assign up_content_o.ta   = ta_q;
  assign up_content_o.fsc  = fsc_q;
  assign done_o            = done_q;
  assign error_o           = error_q;
  assign cause_o           = cause_q;

endmodule
